// File: rtl/stim_gen.sv
// Programmable multi-channel stimulus source: ramp, LFSR or constant patterns
// streamed over valid/ready, with run length, tail gap, abort and a done pulse.
module stim_gen #(
  parameter int unsigned W        = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned MAX_LEN  = 256,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic [LW-1:0]     i_len,
  input  logic [W-1:0]      i_seed,
  input  logic [15:0]       i_gap,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [NCH*W-1:0]  o_data,
  output logic [LW-1:0]     o_count,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StTail = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] ModeLfsr  = 2'd1;
  localparam logic [1:0] ModeConst = 2'd2;

  localparam logic [31:0] MaskWide = (W == 8)  ? 32'h0000_00B8 :
                                     (W == 16) ? 32'h0000_B400 : 32'h8020_0003;
  localparam logic [W-1:0]  Mask   = MaskWide[W-1:0];
  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] len_q, len_d;
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   gcnt_q, gcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          zero_q, zero_d;
  logic [W-1:0]  data_q [NCH];
  logic [W-1:0]  data_d [NCH];

  logic          xfer;
  logic          last;
  logic [LW-1:0] len_sat;

  function automatic logic [W-1:0] first_sample(input logic [1:0] mode,
                                                input logic [W-1:0] seed,
                                                input int unsigned k);
    logic [W-1:0] s;
    if (mode == ModeLfsr) begin
      s = seed ^ W'(k);
      if (s == '0) s = W'(1);
    end else begin
      s = seed + W'(k);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] next_sample(input logic [1:0] mode, input logic [W-1:0] s);
    logic [W-1:0] n;
    if (mode == ModeLfsr) begin
      n = s[0] ? ((s >> 1) ^ Mask) : (s >> 1);
    end else if (mode == ModeConst) begin
      n = s;
    end else begin
      n = s + W'(1);
    end
    return n;
  endfunction

  assign xfer    = valid_q & i_ready;
  assign last    = (count_q + LW'(1)) == len_q;
  assign len_sat = (i_len > MaxLen) ? MaxLen : i_len;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    count_d = count_q;
    len_d   = len_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    mode_d  = mode_q;
    zero_d  = 1'b0;
    for (int k = 0; k < NCH; k++) data_d[k] = data_q[k];

    case (state_q)
      StIdle: begin
        // A zero-length run spends one settle cycle here so done lands two cycles after start.
        if (zero_q) begin
          state_d = StDone;
        end else if (i_start) begin
          mode_d  = i_mode;
          len_d   = len_sat;
          gap_d   = i_gap;
          count_d = '0;
          if (len_sat == '0) begin
            zero_d = 1'b1;
          end else begin
            state_d = StRun;
            valid_d = 1'b1;
            for (int k = 0; k < NCH; k++) data_d[k] = first_sample(i_mode, i_seed, k);
          end
        end
      end
      StRun: begin
        if (xfer) begin
          count_d = count_q + LW'(1);
          for (int k = 0; k < NCH; k++) data_d[k] = next_sample(mode_q, data_q[k]);
        end
        if (i_abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (xfer && last) begin
          valid_d = 1'b0;
          if (gap_q == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StTail;
            gcnt_d  = gap_q;
          end
        end
      end
      StTail: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (gcnt_q == 16'd1) begin
          state_d = StDone;
        end else begin
          gcnt_d = gcnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      mode_q  <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
      for (int k = 0; k < NCH; k++) data_q[k] <= data_d[k];
    end
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NCH; k++) o_data[k*W +: W] = data_q[k];
  end

  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_busy  = (state_q == StRun) || (state_q == StTail);
  assign o_done  = (state_q == StDone);

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: timeline-based reference model checked every cycle,
// plus literal pattern/timing expectations per scenario.
module tb_stim_gen;
  localparam int unsigned W       = 8;
  localparam int unsigned NCH     = 4;
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned LW      = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_abort, i_ready;
  logic [1:0]       i_mode;
  logic [LW-1:0]    i_len;
  logic [W-1:0]     i_seed;
  logic [15:0]      i_gap;
  logic             o_valid, o_busy, o_done;
  logic [NCH*W-1:0] o_data;
  logic [LW-1:0]    o_count;

  stim_gen #(.W(W), .NCH(NCH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_len(i_len), .i_seed(i_seed), .i_gap(i_gap), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_count(o_count), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: expected outputs for the cycle following each edge.
  bit         e_valid, e_busy, e_done, e_zero;
  int         e_count, m_len, m_gap, m_tail, m_due, m_mode;
  logic [7:0] m_seed;

  logic [NCH*W-1:0] cap[$];
  int done_cnt = 0, done_cyc = -1, last_xfer_cyc = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] samp(input int mode, input logic [7:0] seed, input int n,
                                      input int k);
    logic [7:0] s;
    if (mode == 1) begin
      s = seed ^ 8'(k);
      if (s == 8'h00) s = 8'h01;
      for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      return s;
    end
    if (mode == 2) return seed + 8'(k);
    return seed + 8'(n) + 8'(k);
  endfunction

  task automatic model_edge();
    bit idle, xfer;
    idle = !e_busy && !e_done && (m_due < 0);
    xfer = e_valid && i_ready;
    e_done = 1'b0;
    if (rst) begin
      e_valid = 0; e_busy = 0; e_count = 0; m_due = -1; e_zero = 1;
      return;
    end
    if (m_due > 0) begin
      m_due--;
      if (m_due == 0) begin
        e_done = 1; m_due = -1;
      end
    end else if (idle && i_start) begin
      m_mode  = int'(i_mode);
      m_seed  = i_seed;
      m_len   = (int'(i_len) > 256) ? 256 : int'(i_len);
      m_gap   = int'(i_gap);
      e_count = 0;
      e_zero  = 0;
      if (m_len == 0) m_due = 1;
      else begin
        e_valid = 1; e_busy = 1;
      end
    end else if (e_busy) begin
      if (xfer) e_count++;
      if (i_abort) begin
        e_valid = 0; e_busy = 0;
      end else if (xfer && e_count == m_len) begin
        e_valid = 0;
        m_tail  = m_gap;
        if (m_gap == 0) begin
          e_busy = 0; e_done = 1;
        end
      end else if (!e_valid) begin
        m_tail--;
        if (m_tail == 0) begin
          e_busy = 0; e_done = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", o_valid, e_valid);
      chk("busy", o_busy, e_busy);
      chk("done", o_done, e_done);
      chk("count", o_count, e_count);
      if (e_valid) begin
        for (int k = 0; k < NCH; k++) chk("data_ch", o_data[k*W +: W], samp(m_mode, m_seed, e_count, k));
      end else if (e_zero) begin
        chk("data_after_rst", o_data, 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      cap.push_back(o_data);
      last_xfer_cyc = cyc;
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [7:0] seed, input int len,
                           input int gap);
    i_mode = mode; i_seed = seed; i_len = LW'(len); i_gap = 16'(gap);
    i_start = 1'b1;
    cap.delete();
    cycle();
    i_start = 1'b0;
  endtask

  task automatic chk_ch(input string nm, input int k, input logic [7:0] exp[$]);
    chk({nm, "_len"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++) chk(nm, cap[i][k*W +: W], exp[i]);
  endtask

  initial begin
    logic [7:0] q[$];
    int dc, t0;
    rst = 1; i_start = 0; i_abort = 0; i_ready = 1; i_mode = 0; i_len = 0; i_seed = 0; i_gap = 0;
    e_valid = 0; e_busy = 0; e_done = 0; e_zero = 1; e_count = 0; m_due = -1;
    m_len = 0; m_gap = 0; m_tail = 0; m_mode = 0; m_seed = 0;
    cycle();
    chk_en = 1;
    cycle();
    rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_count", o_count, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    run(2);

    // Ramp across the wrap point.
    dc = done_cnt;
    start_run(2'd0, 8'hFE, 4, 0);
    run(6);
    q = {8'hFE, 8'hFF, 8'h00, 8'h01}; chk_ch("ramp_ch0", 0, q);
    q = {8'h01, 8'h02, 8'h03, 8'h04}; chk_ch("ramp_ch3", 3, q);
    chk("ramp_count", o_count, 4);
    chk("ramp_done_cnt", done_cnt - dc, 1);
    chk("ramp_done_lat", done_cyc - last_xfer_cyc, 1);

    // Backpressure while sample 1 is presented, gap 2.
    start_run(2'd0, 8'h10, 5, 2);
    cycle();
    i_ready = 0;
    run(3);
    chk("bp_hold_ch0", o_data[7:0], 8'h11);
    chk("bp_hold_count", o_count, 1);
    i_ready = 1;
    run(10);
    q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14}; chk_ch("bp_ch0", 0, q);
    chk("bp_count", o_count, 5);
    chk("bp_done_lat", done_cyc - last_xfer_cyc, 3);

    // Zero-length run.
    dc = done_cnt;
    t0 = cyc;
    start_run(2'd0, 8'h00, 0, 3);
    run(4);
    chk("len0_done_cnt", done_cnt - dc, 1);
    chk("len0_done_lat", done_cyc - t0, 2);
    chk("len0_no_xfer", cap.size(), 0);

    // Abort on sample 2 with a transfer, then a clean restart.
    dc = done_cnt;
    start_run(2'd0, 8'h20, 10, 3);
    run(2);
    i_abort = 1;
    cycle();
    i_abort = 0;
    chk("abort_valid", o_valid, 0);
    chk("abort_count", o_count, 3);
    run(8);
    chk("abort_no_done", done_cnt - dc, 0);
    start_run(2'd0, 8'h20, 3, 0);
    run(6);
    q = {8'h20, 8'h21, 8'h22}; chk_ch("restart_ch0", 0, q);

    // Abort without a transfer, and abort during the tail.
    dc = done_cnt;
    start_run(2'd0, 8'h30, 10, 0);
    run(2);
    i_ready = 0; i_abort = 1;
    cycle();
    i_abort = 0; i_ready = 1;
    chk("abort_noxfer_count", o_count, 2);
    start_run(2'd0, 8'h30, 2, 6);
    run(4);
    i_abort = 1;
    cycle();
    i_abort = 0;
    run(8);
    chk("abort_tail_no_done", done_cnt - dc, 0);

    // LFSR, CONST and reserved mode.
    start_run(2'd1, 8'h00, 3, 0);
    run(5);
    q = {8'h01, 8'hB8, 8'h5C}; chk_ch("lfsr_ch0", 0, q);
    q = {8'h01, 8'hB8, 8'h5C}; chk_ch("lfsr_ch1", 1, q);
    start_run(2'd2, 8'h40, 3, 1);
    run(6);
    q = {8'h42, 8'h42, 8'h42}; chk_ch("const_ch2", 2, q);
    start_run(2'd3, 8'hF0, 2, 0);
    run(4);
    q = {8'hF1, 8'hF2}; chk_ch("mode3_ch1", 1, q);

    // Length above MAX_LEN saturates.
    start_run(2'd0, 8'h00, 300, 0);
    run(260);
    chk("sat_count", o_count, 256);
    chk("sat_xfers", cap.size(), 256);

    // Reset mid-run with a pending tail.
    dc = done_cnt;
    start_run(2'd0, 8'h50, 10, 5);
    run(3);
    rst = 1;
    cycle();
    rst = 0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_count", o_count, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    run(12);
    chk("midrst_no_done", done_cnt - dc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
